trivium_host: RTL and testbench

Host-side initiator for the Trivium cipher subsystem (cipher core plus output FIFO). It takes a parallel key/IV and a byte stream of plaintext. It then:
- loads the key and IV into the cipher serially over the KEY/STB_KEY interface;
- pushes plaintext bytes over DATA/STB_DATA, limited by FIFO credit;
- drains ciphertext through READ/STB_READ.

It sits between a system-side byte source/sink and the cipher subsystem's top-level ports.

---
 rtl/trivium_host_pkg.sv | 16 +
 rtl/trivium_key_shifter.sv | 47 ++++
 rtl/trivium_host.sv | 204 ++++++++++++++++++++
 tb/tb_trivium_host.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_host_pkg.sv
// Shared types and sizes for the Trivium host initiator.
package trivium_host_pkg;

  localparam int KEY_BITS  = 80;
  localparam int IV_BITS   = 80;
  localparam int LOAD_BITS = KEY_BITS + IV_BITS;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_RDY = 3'd2,
    STREAM   = 3'd3,
    DONE     = 3'd4
  } state_e;

endpackage

// File: rtl/trivium_key_shifter.sv
// Parallel-load, MSB-first serializer; last_o marks the final bit on the line.
module trivium_key_shifter #(
  parameter int W = 160
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         bit_o,
  output logic         last_o
);
  import trivium_host_pkg::*;

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = din;
      cnt_d = '0;
    end else if (shift) begin
      sr_d  = {sr_q[W-2:0], 1'b0};
      cnt_d = cnt_q + CW'(1);
    end else begin
      sr_d  = sr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_o  = sr_q[W-1];
  assign last_o = (cnt_q == CW'(W - 1));

endmodule

// File: rtl/trivium_host.sv
// Host-side sequencer for the Trivium subsystem: serial key/IV load, then
// credit-limited plaintext push and one-at-a-time ciphertext drain.
module trivium_host #(
  parameter int KEY_BITS   = trivium_host_pkg::KEY_BITS,
  parameter int IV_BITS    = trivium_host_pkg::IV_BITS,
  parameter int FIFO_DEPTH = 8,
  parameter int READY_BIT  = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic [IV_BITS-1:0]  iv_in,
  input  logic [7:0]          msg_len,
  input  logic [7:0]          pt_data,
  input  logic                pt_valid,
  output logic                pt_ready,
  output logic [7:0]          ct_data,
  output logic                ct_valid,
  input  logic                ct_ready,
  output logic                KEY,
  output logic                STB_KEY,
  output logic [7:0]          DATA,
  output logic                STB_DATA,
  output logic                READ,
  input  logic [7:0]          DATA_OUT,
  input  logic                STB_READ,
  input  logic [7:0]          SIGN_REG,
  output logic                busy,
  output logic                done
);
  import trivium_host_pkg::*;

  localparam int LW  = KEY_BITS + IV_BITS;
  localparam int CRW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CRW-1:0] DEPTH_C = CRW'(FIFO_DEPTH);

  state_e         state_q, state_d;
  logic [7:0]     len_q, len_d, sent_q, sent_d, recv_q, recv_d;
  logic [CRW-1:0] credit_q, credit_d;
  logic           rd_out_q, rd_out_d;
  logic           pt_ready_q, pt_ready_d, ct_valid_q, ct_valid_d;
  logic [7:0]     ct_data_q, ct_data_d, data_q, data_d;
  logic           stb_key_q, stb_key_d, stb_data_q, stb_data_d;
  logic           read_q, read_d, busy_q, busy_d, done_q, done_d;
  logic           start_ok_s, shift_s, last_s, send_s, recv_s;
  logic           unused_sign_s;

  assign start_ok_s    = (state_q == IDLE) && start;
  assign shift_s       = (state_q == LOAD);
  assign unused_sign_s = ^SIGN_REG;

  trivium_key_shifter #(.W(LW)) u_shifter (
    .clk    (CLK),
    .rst_n  (RST),
    .load   (start_ok_s),
    .shift  (shift_s),
    .din    ({key_in, iv_in}),
    .bit_o  (KEY),
    .last_o (last_s)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    sent_d     = sent_q;
    recv_d     = recv_q;
    credit_d   = credit_q;
    rd_out_d   = rd_out_q;
    ct_valid_d = ct_valid_q;
    ct_data_d  = ct_data_q;
    data_d     = data_q;
    stb_key_d  = 1'b0;
    stb_data_d = 1'b0;
    read_d     = 1'b0;
    done_d     = 1'b0;
    send_s     = 1'b0;
    recv_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          len_d     = msg_len;
          sent_d    = 8'd0;
          recv_d    = 8'd0;
          credit_d  = '0;
          rd_out_d  = 1'b0;
          stb_key_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (last_s) begin
          state_d = WAIT_RDY;
        end else begin
          stb_key_d = 1'b1;
        end
      end
      WAIT_RDY: begin
        if (SIGN_REG[READY_BIT]) begin
          if (len_q == 8'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = STREAM;
          end
        end else begin
          state_d = WAIT_RDY;
        end
      end
      STREAM: begin
        send_s = pt_valid && pt_ready_q;
        // Only a response to our own outstanding READ is accepted.
        recv_s = STB_READ && rd_out_q;
        if (send_s) begin
          data_d     = pt_data;
          stb_data_d = 1'b1;
          sent_d     = sent_q + 8'd1;
        end else begin
          data_d = data_q;
        end
        if (ct_valid_q && ct_ready) begin
          ct_valid_d = 1'b0;
        end else begin
          ct_valid_d = ct_valid_q;
        end
        if (recv_s) begin
          ct_data_d  = DATA_OUT;
          ct_valid_d = 1'b1;
          recv_d     = recv_q + 8'd1;
          rd_out_d   = 1'b0;
        end else if (!rd_out_q && !ct_valid_q && (credit_q != '0)) begin
          read_d   = 1'b1;
          rd_out_d = 1'b1;
        end else begin
          rd_out_d = rd_out_q;
        end
        case ({send_s, recv_s})
          2'b10:   credit_d = credit_q + CRW'(1);
          2'b01:   credit_d = credit_q - CRW'(1);
          default: credit_d = credit_q;
        endcase
        if ((recv_q == len_q) && !ct_valid_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = STREAM;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pt_ready_d = (state_d == STREAM) && (sent_d < len_q) && (credit_d < DEPTH_C);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      len_q      <= 8'd0;
      sent_q     <= 8'd0;
      recv_q     <= 8'd0;
      credit_q   <= '0;
      rd_out_q   <= 1'b0;
      pt_ready_q <= 1'b0;
      ct_valid_q <= 1'b0;
      ct_data_q  <= 8'd0;
      data_q     <= 8'd0;
      stb_key_q  <= 1'b0;
      stb_data_q <= 1'b0;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      sent_q     <= sent_d;
      recv_q     <= recv_d;
      credit_q   <= credit_d;
      rd_out_q   <= rd_out_d;
      pt_ready_q <= pt_ready_d;
      ct_valid_q <= ct_valid_d;
      ct_data_q  <= ct_data_d;
      data_q     <= data_d;
      stb_key_q  <= stb_key_d;
      stb_data_q <= stb_data_d;
      read_q     <= read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pt_ready = pt_ready_q;
  assign ct_valid = ct_valid_q;
  assign ct_data  = ct_data_q;
  assign STB_KEY  = stb_key_q;
  assign DATA     = data_q;
  assign STB_DATA = stb_data_q;
  assign READ     = read_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_trivium_host.sv
// Bench for trivium_host: a cipher-subsystem model (XOR keystream, 8-deep FIFO)
// plus a per-session reference of expected ciphertext and protocol bounds.
module tb_trivium_host;

  logic        clk = 1'b0;
  logic        RST;
  logic        start;
  logic [79:0] key_in, iv_in;
  logic [7:0]  msg_len, pt_data;
  logic        pt_valid, pt_ready;
  logic [7:0]  ct_data;
  logic        ct_valid, ct_ready;
  logic        KEY, STB_KEY, STB_DATA, READ, STB_READ, busy, done;
  logic [7:0]  DATA, DATA_OUT, SIGN_REG;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  trivium_host dut (
    .CLK(clk), .RST(RST), .start(start), .key_in(key_in), .iv_in(iv_in),
    .msg_len(msg_len), .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready), .KEY(KEY),
    .STB_KEY(STB_KEY), .DATA(DATA), .STB_DATA(STB_DATA), .READ(READ),
    .DATA_OUT(DATA_OUT), .STB_READ(STB_READ), .SIGN_REG(SIGN_REG),
    .busy(busy), .done(done)
  );

  function automatic logic [7:0] ks(input int i);
    logic [7:0] t;
    t = 8'(i);
    return (t * 8'd29 + 8'h5B) ^ 8'hC3;
  endfunction

  function automatic logic [79:0] rnd80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cipher subsystem model: keystream XOR, FIFO, one-cycle read latency, ready flag.
  logic [7:0] fifo_q[$];
  int dev_kcnt, dev_dly, dev_ks;
  always @(posedge clk) begin
    if (!RST) begin
      fifo_q.delete();
      SIGN_REG <= 8'h00;
      STB_READ <= 1'b0;
      DATA_OUT <= 8'h00;
      dev_kcnt <= 0;
      dev_dly  <= 0;
      dev_ks   <= 0;
    end else begin
      STB_READ <= 1'b0;
      if (READ && fifo_q.size() > 0) begin
        DATA_OUT <= fifo_q.pop_front();
        STB_READ <= 1'b1;
      end
      if (STB_DATA) begin
        fifo_q.push_back(DATA ^ ks(dev_ks));
        dev_ks <= dev_ks + 1;
      end
      if (STB_KEY) begin
        dev_kcnt <= (dev_kcnt == 160) ? 1 : dev_kcnt + 1;
        SIGN_REG <= 8'h5A;
        dev_dly  <= $urandom_range(0, 4);
        dev_ks   <= 0;
      end else if (dev_kcnt == 160 && !SIGN_REG[0]) begin
        if (dev_dly == 0) SIGN_REG <= 8'h5B;
        else dev_dly <= dev_dly - 1;
      end
    end
  end

  // mode 0: fixed bytes i*0x11, always valid/ready; 1: random handshakes;
  // 2: ct_ready held low until the credit stall is seen, then random.
  task automatic run_session(input logic [79:0] k, input logic [79:0] v, input int len,
                             input int mode, input int abort_at);
    logic [7:0]   pt[$];
    logic [7:0]   expq[$];
    logic [7:0]   b;
    logic [159:0] kbits = '0;
    int kcnt = 0, kfirst = -1, klast = -1, data_in_load = 0, n_stb_data = 0;
    int n_read = 0, rd_viol = 0, pt_over = 0, ndone = 0, done_cyc = -1, rdy_cyc = -1;
    int sent = 0, got = 0, credit = 0, max_credit = 0, lowrun = 0;
    bit outstanding = 1'b0, stalled = 1'b0, fin = 1'b0;

    for (int i = 0; i < len; i++) begin
      b = (mode == 0) ? 8'(i * 17) : 8'($urandom());
      pt.push_back(b);
      expq.push_back(b ^ ks(i));
    end
    @(negedge clk);
    key_in = k; iv_in = v; msg_len = 8'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (STB_KEY) begin
        kbits = {kbits[158:0], KEY};
        kcnt++;
        if (kfirst < 0) kfirst = cyc;
        klast = cyc;
      end
      if (STB_DATA) begin
        n_stb_data++;
        if (kcnt < 160) data_in_load++;
      end
      if (READ) begin
        n_read++;
        if (outstanding) rd_viol++;
      end
      if (STB_READ) begin
        outstanding = 1'b0;
        credit--;
      end
      if (READ) outstanding = 1'b1;
      if (SIGN_REG[0] && rdy_cyc < 0 && kcnt == 160) rdy_cyc = cyc;
      if (done) begin
        ndone++;
        done_cyc = cyc;
        fin = 1'b1;
      end
      // a second start while busy must be ignored
      start   = (cyc == 5);
      msg_len = 8'($urandom());
      key_in  = rnd80();
      case (mode)
        0:       ct_ready = 1'b1;
        2:       ct_ready = stalled && ($urandom_range(0, 1) == 1);
        default: ct_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (ct_ready && ct_valid) begin
        if (expq.size() > 0) chk("ct_byte", ct_data, expq.pop_front());
        else chk("ct_extra", got, len - 1);
        got++;
      end
      pt_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      pt_data  = (sent < len) ? pt[sent] : 8'($urandom());
      if (pt_valid && pt_ready) begin
        if (sent < len) begin
          sent++;
          credit++;
        end else begin
          pt_over++;
        end
      end
      if (credit > max_credit) max_credit = credit;
      if (mode == 2 && !stalled) begin
        if (!pt_ready && sent > 0) lowrun++;
        else lowrun = 0;
        if (lowrun == 20) begin
          chk("stall_sent", sent, 9);
          chk("stall_hold", ct_valid, 1);
          stalled = 1'b1;
        end
      end
      if (abort_at > 0 && got == abort_at) break;
      if (!fin) @(negedge clk);
    end
    start = 1'b0;

    if (abort_at > 0) begin
      chk("abort_reached", got, abort_at);
      RST = 1'b0; pt_valid = 1'b0; ct_ready = 1'b0;
      @(posedge clk); #1;
      chk("abort_outs", {pt_ready, ct_valid, ct_data, KEY, STB_KEY, DATA, STB_DATA, READ, busy, done}, '0);
      chk("abort_nodone", ndone, 0);
      @(negedge clk);
      RST = 1'b1;
      return;
    end

    chk("done_once", ndone, 1);
    chk("ct_count", got, len);
    chk("sent_count", sent, len);
    chk("pt_over", pt_over, 0);
    chk("stb_data_count", n_stb_data, len);
    chk("read_count", n_read, len);
    chk("read_overlap", read_viol_fix(rd_viol), 0);
    chk("credit_le_depth", (max_credit <= 8), 1);
    chk("key_bits", kbits, {k, v});
    chk("key_first", kfirst, 0);
    chk("key_span", klast - kfirst + 1, 160);
    chk("key_cnt", kcnt, 160);
    chk("data_in_load", data_in_load, 0);
    if (len == 0) chk("zero_done_lat", done_cyc - rdy_cyc, 1);
    if (mode == 2) chk("stall_seen", stalled, 1);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
  endtask

  function automatic int read_viol_fix(input int x);
    return x;
  endfunction

  initial begin
    RST = 1'b0; start = 1'b0; key_in = '0; iv_in = '0; msg_len = 8'd0;
    pt_data = 8'd0; pt_valid = 1'b0; ct_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pt_ready", pt_ready, 0);
    chk("rst_ct_valid", ct_valid, 0);
    chk("rst_ct_data", ct_data, 0);
    chk("rst_key", {KEY, STB_KEY}, 0);
    chk("rst_data", {DATA, STB_DATA}, 0);
    chk("rst_read", READ, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    RST = 1'b1;

    run_session(80'h0123456789ABCDEF0123, 80'hFEDCBA9876543210FEDC, 4, 0, 0);
    run_session(rnd80(), rnd80(), 12, 2, 0);
    run_session(rnd80(), rnd80(), 0, 1, 0);
    for (int s = 0; s < 4; s++) run_session(rnd80(), rnd80(), $urandom_range(1, 20), 1, 0);
    run_session(rnd80(), rnd80(), 10, 1, 3);
    run_session(rnd80(), rnd80(), 6, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
